// File: rtl/letc_axi_scratchpad.sv
// AXI4 subordinate backed by a word-addressed SRAM. It serves one transaction at a time,
// supports INCR and FIXED bursts, and reports DECERR/SLVERR for bad requests.
module letc_axi_scratchpad #(
  parameter int          DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          ID_WIDTH    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic [31:0]         awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                wvalid,
  output logic                wready,
  input  logic [31:0]         wdata,
  input  logic [3:0]          wstrb,
  input  logic                wlast,
  output logic                bvalid,
  input  logic                bready,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [31:0]         araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  output logic                rvalid,
  input  logic                rready,
  output logic [ID_WIDTH-1:0] rid,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rlast
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {IDLE, WR_DATA, WR_RESP, RD_DATA} state_t;
  state_t state_reg, state_next;

  logic          rr_last_was_write;
  logic [31:0]   addr_reg;
  logic [7:0]    len_reg;
  logic [7:0]    beat_reg;
  logic [2:0]    size_reg;
  logic          fixed_reg;
  logic [1:0]    err_reg;
  logic          wlast_bad_reg;
  logic          rd_issue_reg;
  logic          rdata_ok_reg;
  logic [31:0]   mem_q;
  logic [AW-1:0] word_idx;
  logic          mem_we;

  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic [2:0]  req_size;
  logic [1:0]  req_burst;
  logic [1:0]  req_err;
  logic [33:0] req_off;
  logic [33:0] req_last_off;

  always_comb begin
    state_next = state_reg;
    awready    = 1'b0;
    arready    = 1'b0;
    wready     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (awvalid && (!arvalid || !rr_last_was_write)) begin
          awready    = 1'b1;
          state_next = WR_DATA;
        end else if (arvalid) begin
          arready    = 1'b1;
          state_next = RD_DATA;
        end
      end
      WR_DATA: begin
        wready = 1'b1;
        if (wvalid && beat_reg == len_reg) state_next = WR_RESP;
      end
      WR_RESP: if (bready) state_next = IDLE;
      RD_DATA: if (rvalid && rready && rlast) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Range check covers the first and last beat; a negative offset sets bit 33.
  always_comb begin
    req_addr     = awready ? awaddr  : araddr;
    req_len      = awready ? awlen   : arlen;
    req_size     = awready ? awsize  : arsize;
    req_burst    = awready ? awburst : arburst;
    req_off      = 34'(req_addr) - 34'(BASE_ADDR);
    req_last_off = req_off + ((req_burst == 2'b00) ? 34'd0 : (34'(req_len) << req_size));
    if (req_burst[1] || req_size > 3'd2)
      req_err = RESP_SLVERR;
    else if (req_off[33] || req_last_off[33] || req_last_off >= 34'(DEPTH_WORDS * 4))
      req_err = RESP_DECERR;
    else
      req_err = RESP_OKAY;
  end

  assign bvalid   = (state_reg == WR_RESP);
  assign rdata    = rdata_ok_reg ? mem_q : 32'd0;
  assign word_idx = AW'((addr_reg - BASE_ADDR) >> 2);
  assign mem_we   = wready && wvalid && (err_reg == RESP_OKAY);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg         <= IDLE;
      rr_last_was_write <= 1'b0;
      addr_reg          <= '0;
      len_reg           <= '0;
      beat_reg          <= '0;
      size_reg          <= '0;
      fixed_reg         <= 1'b0;
      err_reg           <= RESP_OKAY;
      wlast_bad_reg     <= 1'b0;
      rd_issue_reg      <= 1'b0;
      rdata_ok_reg      <= 1'b0;
      rvalid            <= 1'b0;
      rlast             <= 1'b0;
      rresp             <= RESP_OKAY;
      bresp             <= RESP_OKAY;
      bid               <= '0;
      rid               <= '0;
    end else begin
      state_reg <= state_next;
      if (awready || arready) begin
        rr_last_was_write <= awready;
        addr_reg          <= req_addr;
        len_reg           <= req_len;
        size_reg          <= req_size;
        fixed_reg         <= (req_burst == 2'b00);
        err_reg           <= req_err;
        beat_reg          <= '0;
        wlast_bad_reg     <= 1'b0;
        if (awready) begin
          bid <= awid;
        end else begin
          rid          <= arid;
          rd_issue_reg <= 1'b1;
        end
      end
      if (wready && wvalid) begin
        if (wlast != (beat_reg == len_reg)) wlast_bad_reg <= 1'b1;
        beat_reg <= beat_reg + 8'd1;
        if (!fixed_reg) addr_reg <= addr_reg + (32'd1 << size_reg);
        if (beat_reg == len_reg)
          bresp <= (err_reg == RESP_SLVERR || wlast_bad_reg || !wlast) ? RESP_SLVERR : err_reg;
      end
      // The SRAM word lands in mem_q on the same edge that raises rvalid.
      if (rd_issue_reg) begin
        rd_issue_reg <= 1'b0;
        rvalid       <= 1'b1;
        rlast        <= (beat_reg == len_reg);
        rresp        <= err_reg;
        rdata_ok_reg <= (err_reg == RESP_OKAY);
      end
      if (rvalid && rready) begin
        rvalid <= 1'b0;
        rlast  <= 1'b0;
        if (!rlast) begin
          beat_reg     <= beat_reg + 8'd1;
          rd_issue_reg <= 1'b1;
          if (!fixed_reg) addr_reg <= addr_reg + (32'd1 << size_reg);
        end
      end
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic [7:0] lane_mem [DEPTH_WORDS];
    logic [7:0] lane_q;
    always_ff @(posedge i_clk) begin
      if (mem_we && wstrb[gi]) lane_mem[word_idx] <= wdata[8*gi +: 8];
      if (rd_issue_reg) lane_q <= lane_mem[word_idx];
    end
    assign mem_q[8*gi +: 8] = lane_q;
  end

  a_r_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (rvalid && !rready) |=> (rvalid && $stable(rdata) && $stable(rresp) && $stable(rlast) && $stable(rid)));
  a_b_stable: assert property (@(posedge i_clk) disable iff (!i_rst_n)
    (bvalid && !bready) |=> (bvalid && $stable(bresp) && $stable(bid)));
  a_one_grant: assert property (@(posedge i_clk) disable iff (!i_rst_n) !(awready && arready));

endmodule
